// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_W       = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible requester at or after ptr.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] excl,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] cand;

    assign cand = req & ~excl;

    // Scan farthest offset first so the nearest candidate wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[ptr + SEL_W'(i)]) begin
                idx   = ptr + SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded hold, driving a shared 4:1 data mux.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

    state_t              state;
    logic [SEL_W-1:0]    ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SEL_W-1:0]    pick_idx;
    logic                pick_found;
    logic                own_req;
    logic                others;

    assign own_req = |(req & gnt);
    assign others  = |(req & ~gnt);

    // gnt is zero in IDLE, so excluding it only matters while owned.
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= OWNED;
                        gnt      <= onehot(pick_idx);
                        sel      <= pick_idx;
                        ptr      <= pick_idx + SEL_W'(1);
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                OWNED: begin
                    if (own_req && (!others || hold_cnt < MAX_H)) begin
                        if (hold_cnt < MAX_H)
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else if (pick_found) begin
                        gnt      <= onehot(pick_idx);
                        sel      <= pick_idx;
                        ptr      <= pick_idx + SEL_W'(1);
                        hold_cnt <= HOLD_W'(1);
                    end else begin
                        state    <= IDLE;
                        gnt      <= '0;
                        hold_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign busy = |gnt;

    always_comb begin
        y = 1'b0;
        if (busy)
            y = din[sel];
    end

endmodule
